// File: rtl/spi_pkg.sv
// Shared types for the SPI slave engine.
// Engine states and frame opcodes.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RX      = 2'd1,
    WAIT_TX = 2'd2,
    TX      = 2'd3
  } spi_state_t;

  typedef enum logic [1:0] {
    WR_ADDR = 2'd0,
    WR_DATA = 2'd1,
    RD_ADDR = 2'd2,
    RD_DATA = 2'd3
  } spi_op_t;

endpackage

// File: rtl/spi_tx_shifter.sv
// Read-data serialiser for the SPI slave engine.
// Shifts one DATA_W word out on miso, one bit per clk.
module spi_tx_shifter #(
  parameter int DATA_W    = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              abort,
  output logic              miso,
  output logic              miso_oe,
  output logic              done
);

  localparam int BW = $clog2(DATA_W);

  logic [DATA_W-1:0] sreg;
  logic [BW-1:0]     bcnt;
  logic              oe;

  logic head;

  assign head    = (LSB_FIRST != 0) ? sreg[0] : sreg[DATA_W-1];
  assign miso    = oe & head;
  assign miso_oe = oe;
  assign done    = oe && (bcnt == BW'(DATA_W-1));

  // Load, shift and stop after the last bit; abort wins over all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      bcnt <= '0;
      oe   <= 1'b0;
    end else if (abort) begin
      bcnt <= '0;
      oe   <= 1'b0;
    end else if (load) begin
      sreg <= tx_data;
      bcnt <= '0;
      oe   <= 1'b1;
    end else if (oe) begin
      if (done) begin
        bcnt <= '0;
        oe   <= 1'b0;
      end else begin
        bcnt <= bcnt + 1'b1;
        if (LSB_FIRST != 0)
          sreg <= {1'b0, sreg[DATA_W-1:1]};
        else
          sreg <= {sreg[DATA_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/spi_slave_engine.sv
// SPI slave protocol engine: deframes {cmd,payload}
// frames from mosi and returns read data on miso.
module spi_slave_engine
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CMD_W     = 2,
  parameter int LSB_FIRST = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ss_n,
  input  logic                    mosi,
  output logic                    miso,
  output logic                    miso_oe,
  output logic                    rx_valid,
  output logic [CMD_W+DATA_W-1:0] rx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  input  logic [DATA_W-1:0]       tx_data,
  output logic                    busy,
  output logic                    frame_err
);

  localparam int FRAME_W = CMD_W + DATA_W;
  localparam int CW      = $clog2(FRAME_W + 1);

  spi_state_t        state;
  spi_state_t        state_nx;
  logic [CW-1:0]     cnt;
  logic [CMD_W-1:0]  cmd_q;
  logic [DATA_W-1:0] pay_q;
  logic [DATA_W-1:0] pay_nx;
  spi_op_t           op;

  logic sample;
  logic in_cmd;
  logic last;
  logic load;
  logic done;
  logic err_nx;

  assign sample   = (state == RX) && !ss_n;
  assign in_cmd   = cnt < CW'(CMD_W);
  assign last     = cnt == CW'(FRAME_W - 1);
  assign op       = spi_op_t'(cmd_q[CMD_W-1 -: 2]);
  assign tx_ready = (state == WAIT_TX);
  assign load     = tx_ready && tx_valid && !ss_n;
  assign err_nx   = ss_n && (((state == RX) && (cnt != '0))
                    || (state == WAIT_TX) || (state == TX));

  // Payload with the current mosi bit folded in.
  always_comb begin
    pay_nx = pay_q;
    if (LSB_FIRST != 0)
      pay_nx = {mosi, pay_q[DATA_W-1:1]};
    else
      pay_nx = {pay_q[DATA_W-2:0], mosi};
  end

  // Next-state selection; deselect wins everywhere.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (!ss_n) state_nx = RX;
      RX:      if (ss_n) state_nx = IDLE;
               else if (last && op == RD_DATA) state_nx = WAIT_TX;
      WAIT_TX: if (ss_n) state_nx = IDLE;
               else if (tx_valid) state_nx = TX;
      TX:      if (ss_n) state_nx = IDLE;
               else if (done) state_nx = RX;
      default: state_nx = IDLE;
    endcase
  end

  // State, status pulses, bit counter and frame capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      cnt       <= '0;
      cmd_q     <= '0;
      pay_q     <= '0;
      rx_data   <= '0;
    end else begin
      state     <= state_nx;
      busy      <= (state_nx != IDLE);
      rx_valid  <= sample && last;
      frame_err <= err_nx;
      if (!sample || last)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (sample) begin
        if (in_cmd)
          cmd_q <= {cmd_q[CMD_W-2:0], mosi};
        else
          pay_q <= pay_nx;
        if (last)
          rx_data <= {cmd_q, pay_nx};
      end
    end
  end

  spi_tx_shifter #(
    .DATA_W    (DATA_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .tx_data (tx_data),
    .abort   (ss_n),
    .miso    (miso),
    .miso_oe (miso_oe),
    .done    (done)
  );

endmodule

// File: tb/tb_spi_slave_engine.sv
// Directed bench for spi_slave_engine: default, LSB-first
// and wide (CMD_W=4, DATA_W=16) instances.
module tb_spi_slave_engine;

  logic clk = 1'b0;
  logic rst_n;
  logic ss;
  logic mosi;
  logic txv;
  logic [15:0] txd;
  int sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic ss0, ss1, ss2;
  assign ss0 = (sel == 0) ? ss : 1'b1;
  assign ss1 = (sel == 1) ? ss : 1'b1;
  assign ss2 = (sel == 2) ? ss : 1'b1;

  logic miso0, oe0, rv0, txr0, busy0, fe0;
  logic miso1, oe1, rv1, txr1, busy1, fe1;
  logic miso2, oe2, rv2, txr2, busy2, fe2;
  logic [9:0]  rxd0;
  logic [9:0]  rxd1;
  logic [19:0] rxd2;

  spi_slave_engine #(.DATA_W(8), .CMD_W(2), .LSB_FIRST(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ss_n(ss0), .mosi(mosi),
    .miso(miso0), .miso_oe(oe0), .rx_valid(rv0), .rx_data(rxd0),
    .tx_valid(txv), .tx_ready(txr0), .tx_data(txd[7:0]),
    .busy(busy0), .frame_err(fe0)
  );

  spi_slave_engine #(.DATA_W(8), .CMD_W(2), .LSB_FIRST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ss_n(ss1), .mosi(mosi),
    .miso(miso1), .miso_oe(oe1), .rx_valid(rv1), .rx_data(rxd1),
    .tx_valid(txv), .tx_ready(txr1), .tx_data(txd[7:0]),
    .busy(busy1), .frame_err(fe1)
  );

  spi_slave_engine #(.DATA_W(16), .CMD_W(4), .LSB_FIRST(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .ss_n(ss2), .mosi(mosi),
    .miso(miso2), .miso_oe(oe2), .rx_valid(rv2), .rx_data(rxd2),
    .tx_valid(txv), .tx_ready(txr2), .tx_data(txd),
    .busy(busy2), .frame_err(fe2)
  );

  logic o_miso, o_oe, o_rv, o_txr, o_busy, o_fe;
  logic [19:0] o_rxd;

  always_comb begin
    o_miso = miso0; o_oe = oe0; o_rv = rv0;
    o_txr = txr0; o_busy = busy0; o_fe = fe0;
    o_rxd = 20'(rxd0);
    if (sel == 1) begin
      o_miso = miso1; o_oe = oe1; o_rv = rv1;
      o_txr = txr1; o_busy = busy1; o_fe = fe1;
      o_rxd = 20'(rxd1);
    end else if (sel == 2) begin
      o_miso = miso2; o_oe = oe2; o_rv = rv2;
      o_txr = txr2; o_busy = busy2; o_fe = fe2;
      o_rxd = rxd2;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d: observed %h expected %h",
             tag, sel, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [19:0] f, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = f[i];
      tick();
    end
    mosi = 1'b0;
  endtask

  task automatic open_win();
    ss = 1'b0;
    tick();
    chk("busy_open", 32'(o_busy), 1);
  endtask

  task automatic close_win(input logic exp_err);
    ss = 1'b1;
    tick();
    chk("close_err", 32'(o_fe), 32'(exp_err));
    chk("close_rv", 32'(o_rv), 0);
    chk("close_busy", 32'(o_busy), 0);
    chk("close_oe", 32'(o_oe), 0);
    tick();
    chk("err_pulse_end", 32'(o_fe), 0);
  endtask

  task automatic do_read(input logic [15:0] d, input int w,
                         input bit lsb);
    chk("tx_ready", 32'(o_txr), 1);
    txv = 1'b1;
    txd = d;
    tick();
    txv = 1'b0;
    for (int i = 0; i < w; i++) begin
      chk("miso_oe", 32'(o_oe), 1);
      chk("miso", 32'(o_miso), 32'(lsb ? d[i] : d[w-1-i]));
      chk("tx_ready_tx", 32'(o_txr), 0);
      tick();
    end
    chk("oe_after", 32'(o_oe), 0);
    chk("miso_after", 32'(o_miso), 0);
    chk("busy_after", 32'(o_busy), 1);
  endtask

  task automatic chk_reset_state();
    chk("rst_miso", 32'(o_miso), 0);
    chk("rst_oe", 32'(o_oe), 0);
    chk("rst_rv", 32'(o_rv), 0);
    chk("rst_rxd", 32'(o_rxd), 0);
    chk("rst_txr", 32'(o_txr), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_fe", 32'(o_fe), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    ss    = 1'b1;
    mosi  = 1'b0;
    txv   = 1'b0;
    txd   = '0;
    sel   = 0;
    repeat (2) tick();
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      chk_reset_state();
    end
    rst_n = 1'b1;
    sel = 0;
    tick();

    // single write frame
    open_win();
    send_bits(20'h0A5, 10);
    chk("t1_rv", 32'(o_rv), 1);
    chk("t1_rxd", 32'(o_rxd), 32'h0A5);
    close_win(1'b0);

    // two streamed frames
    open_win();
    send_bits(20'h10F, 10);
    chk("t2_rv1", 32'(o_rv), 1);
    chk("t2_rxd1", 32'(o_rxd), 32'h10F);
    send_bits(20'h1, 1);
    chk("t2_rv_gap", 32'(o_rv), 0);
    send_bits(20'h0F0, 9);
    chk("t2_rv2", 32'(o_rv), 1);
    chk("t2_rxd2", 32'(o_rxd), 32'h2F0);
    close_win(1'b0);

    // read with late tx_valid
    open_win();
    send_bits(20'h35A, 10);
    chk("t3_rxd", 32'(o_rxd), 32'h35A);
    chk("t3_txr0", 32'(o_txr), 1);
    tick();
    chk("t3_txr1", 32'(o_txr), 1);
    chk("t3_oe_wait", 32'(o_oe), 0);
    tick();
    do_read(16'h00C3, 8, 1'b0);
    send_bits(20'h300, 10);
    do_read(16'h001C, 8, 1'b0);
    close_win(1'b0);

    // LSB-first instance
    sel = 1;
    open_win();
    send_bits(20'h138, 10);
    chk("t4_rv", 32'(o_rv), 1);
    chk("t4_rxd", 32'(o_rxd), 32'h11C);
    send_bits(20'h300, 10);
    do_read(16'h00C3, 8, 1'b1);
    send_bits(20'h300, 10);
    do_read(16'h001C, 8, 1'b1);
    close_win(1'b0);

    // aborts
    sel = 0;
    open_win();
    send_bits(20'hA, 4);
    close_win(1'b1);
    open_win();
    send_bits(20'h2A, 9);
    mosi = 1'b1;
    close_win(1'b1);
    open_win();
    send_bits(20'h3FF, 10);
    txv = 1'b1;
    txd = 16'h00FF;
    tick();
    txv = 1'b0;
    repeat (3) tick();
    chk("t5_oe_tx", 32'(o_oe), 1);
    close_win(1'b1);
    open_win();
    send_bits(20'h300, 10);
    txv = 1'b1;
    txd = 16'h00FF;
    close_win(1'b1);
    txv = 1'b0;

    // async reset during TX
    open_win();
    send_bits(20'h300, 10);
    txv = 1'b1;
    txd = 16'h00FF;
    tick();
    txv = 1'b0;
    tick();
    chk("t6_oe_pre", 32'(o_oe), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state();
    ss = 1'b1;
    #1;
    rst_n = 1'b1;
    tick();
    chk_reset_state();

    // wide instance
    sel = 2;
    open_win();
    send_bits(20'h9BEEF, 20);
    chk("t6_rv", 32'(o_rv), 1);
    chk("t6_rxd", 32'(o_rxd), 32'h9BEEF);
    send_bits(20'h31234, 20);
    chk("t6_rxd2", 32'(o_rxd), 32'h31234);
    close_win(1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
